// File: rtl/ram_arbiter_pkg.sv
// Shared constants and state encoding for the two-requester RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 28;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned NUM_REQ        = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: both requesters share one bundle.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, busy
    );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    // One-hot winner selection
    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of an asynchronous-style SRAM with a shared
// bidirectional data bus. One access takes a grant cycle plus an access cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                state;
    logic                  last;
    logic                  lat_id;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [NUM_REQ-1:0]    rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    logic [NUM_REQ-1:0]    pick;
    logic                  win_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    rr_arbiter2 u_rr (
        .req  (bus.req),
        .last (last),
        .gnt  (pick)
    );

    // Winner's request fields, selected by the one-hot pick
    always_comb begin
        win_id    = pick[1];
        win_we    = win_id ? bus.we[1] : bus.we[0];
        win_addr  = win_id ? bus.addr[ADDR_WIDTH +: ADDR_WIDTH]
                           : bus.addr[0 +: ADDR_WIDTH];
        win_wdata = win_id ? bus.wdata[DATA_WIDTH +: DATA_WIDTH]
                           : bus.wdata[0 +: DATA_WIDTH];
    end

    // Grants only in IDLE and never while reset is asserted
    assign bus.gnt    = ((state == ST_IDLE) && !rst) ? pick : '0;
    assign bus.busy   = (state == ST_ACCESS);
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata;

    // ram_we is only high in ACCESS of a write, so it doubles as the bus drive enable
    assign ram_data = ram_we ? lat_wdata : {DATA_WIDTH{1'bz}};

    // Arbiter FSM with registered RAM controls and read-return path
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            lat_id    <= 1'b0;
            lat_wdata <= '0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rvalid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state     <= ST_ACCESS;
                        last      <= win_id;
                        lat_id    <= win_id;
                        lat_wdata <= win_wdata;
                        ram_addr  <= win_addr;
                        ram_cs    <= 1'b1;
                        ram_we    <= win_we;
                        ram_oe    <= !win_we;
                    end
                end
                ST_ACCESS: begin
                    state  <= ST_IDLE;
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    if (!ram_we) begin
                        rdata  <= ram_data;
                        rvalid <= lat_id ? 2'b10 : 2'b01;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 28, RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 16, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-requester access request; bit i = requester i.
REQ-006 we  input  2  per-requester direction: 1 = write, 0 = read; sampled with req.
REQ-007 addr  input  2*ADDR_WIDTH  per-requester address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wdata  input  2*DATA_WIDTH  per-requester write data; same slicing.
REQ-009 gnt  output  2  combinational one-hot accept; req[i] & gnt[i] = transfer.
REQ-010 rvalid  output  2  one-cycle pulse; read data for requester i is on rdata.
REQ-011 rdata  output  DATA_WIDTH  registered read data, shared by both requesters.
REQ-012 busy  output  1  high while state = ACCESS.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_data  inout  DATA_WIDTH  RAM bidirectional data bus.
REQ-015 ram_cs  output  1  RAM chip select.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_oe  output  1  RAM output enable.

Function
REQ-018 FSM has two states: IDLE and ACCESS. IDLE goes to ACCESS on any req. ACCESS always returns to IDLE after one cycle.
REQ-019 In IDLE, gnt is one-hot to the arbitration winner when req != 0, else 0. gnt is 0 in ACCESS.
REQ-020 Round-robin arbitration: when both requesters request, grant the one not granted last. With a single request, grant it regardless of priority.
REQ-021 At the edge ending a grant cycle T, latch the winner's id, we, addr slice and wdata slice, then enter ACCESS.
REQ-022 In ACCESS (cycle T+1), ram_cs = 1, ram_we = latched we, ram_oe = ~latched we, ram_addr = latched addr. All are registered; no combinational path from req.
REQ-023 ram_data is driven with latched wdata only in ACCESS with latched we = 1; otherwise high-Z. The arbiter never drives the bus while ram_oe = 1.
REQ-024 Write: the RAM commits at the edge ending T+1. No rvalid is produced.
REQ-025 Read: the RAM presents data in the second half of T+1. rdata captures ram_data at the edge ending T+1. rvalid[id] = 1 during T+2 only.
REQ-026 Read latency: grant in T, data in T+2. Peak throughput: one access per 2 cycles. A new grant is possible in T+2, overlapping the rvalid pulse.
REQ-027 In IDLE, ram_cs, ram_we and ram_oe are 0. ram_addr holds its last value.
REQ-028 rdata holds its value until the next read completes.
REQ-029 req or we changing during ACCESS has no effect; requests are re-evaluated in the next IDLE.

Reset
REQ-030 On rst: state = IDLE; ram_cs = ram_we = ram_oe = 0; ram_addr = 0; ram_data = high-Z; rvalid = 0; rdata = 0; gnt = 0; last-grant pointer = 1, so requester 0 wins the first tie.
REQ-031 rst sampled at the edge ending an ACCESS cycle:
- a write still commits, because the RAM samples the same edge;
- a read's rvalid is suppressed;
- rst takes priority over every other update.

Structure
REQ-032 Shared package holds ADDR_WIDTH and DATA_WIDTH defaults, the IDLE/ACCESS state encoding and the requester-count constant (2).
REQ-033 Sub-module rr_arbiter2 implements the two-way round-robin picker: inputs req and last-grant pointer; output one-hot gnt.

Verification
REQ-034 Write then read: requester 0 writes addr 0x0000010 = 0xBEEF, then reads 0x0000010. Required: ram_cs/ram_we high for exactly 1 cycle on the write; rvalid = 2'b01 two cycles after the read grant; rdata = 0xBEEF.
REQ-035 Simultaneous requests: both requesters request continuously after reset. Required: grants alternate 01, 10, 01, 10, one grant every 2 cycles.
REQ-036 Hold-off: requester 1 asserts req during ACCESS of requester 0's transfer. Required: gnt = 0 in ACCESS; gnt = 2'b10 in the next IDLE.
REQ-037 Bus direction: write cycle, then read cycle. Required: arbiter drives ram_data only while ram_we = 1; never drives it while ram_oe = 1; no X on ram_data.
REQ-038 Reset mid-operation: rst asserted during ACCESS of a read from requester 1. Required: rvalid stays 0; all RAM controls are 0 the following cycle; first post-reset tie goes to requester 0.
